prio_enc_rr: RTL and testbench

PRIO_ENC_RR -- requirements
Module: prio_enc_rr

---
 rtl/prio_enc_rr_pkg.sv | 25 ++
 rtl/prio_enc_rr_search.sv | 50 +++++
 rtl/prio_enc_rr.sv | 117 +++++++++++
 tb/tb_prio_enc_rr.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/prio_enc_rr_pkg.sv
// -----------------------------------------------------------------------------
// prio_enc_rr_pkg
// Purpose : shared types and helpers for the round-robin priority encoder.
//           Holds the priority-mode enum, the widest supported request
//           vector, and a "two or more bits set" helper.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package prio_enc_rr_pkg;

  // Widest request vector the encoder is built for.
  localparam int unsigned PE_MAX_WIDTH = 64;

  // Priority mode as seen on rr_en.
  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } prio_mode_e;

  // True when the vector has two or more bits set. Clearing the lowest set
  // bit leaves a non-zero value only if another bit was set.
  function automatic logic pe_multi(input logic [PE_MAX_WIDTH-1:0] v);
    return (v & (v - {{(PE_MAX_WIDTH-1){1'b0}}, 1'b1})) != '0;
  endfunction

endpackage

// File: rtl/prio_enc_rr_search.sv
// -----------------------------------------------------------------------------
// prio_search
// Purpose : combinational masked priority search. Finds the first set bit of
//           req searching upward from ptr, wrapping to bit 0. With ptr=0 this
//           is a plain lowest-index-wins encoder.
// Ports   : req   [WIDTH-1:0] request vector
//           ptr   [IDX_W-1:0] search start position (always < WIDTH)
//           index [IDX_W-1:0] winning bit position, 0 when req is all-zero
//           none              req is all-zero
//           multi             req has two or more bits set
// -----------------------------------------------------------------------------
module prio_search
  import prio_enc_rr_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] index,
  output logic             none,
  output logic             multi
);

  logic [WIDTH-1:0] upper_mask;
  logic [WIDTH-1:0] masked;
  logic [WIDTH-1:0] search;

  always_comb begin
    upper_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i >= int'(ptr)) upper_mask[i] = 1'b1;
    end

    // Requests at or above ptr take precedence; if there are none, the
    // search wraps and the lowest request overall wins.
    masked = req & upper_mask;
    search = (masked != '0) ? masked : req;

    // Scan downward so the lowest set bit is the last one written.
    index = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (search[i]) index = IDX_W'(i);
    end

    none  = (req == '0);
    multi = pe_multi(PE_MAX_WIDTH'(req));
  end

endmodule

// File: rtl/prio_enc_rr.sv
// -----------------------------------------------------------------------------
// prio_enc_rr
// Purpose : priority encoder with selectable fixed / round-robin priority and a
//           single-entry registered output with valid/ready handshake.
//           Latency 1, full throughput when the consumer is ready.
// Ports   : clk, rst_n        clock, asynchronous active-low reset
//           enable            gates acceptance of new requests only
//           rr_en             0 = lowest index wins, 1 = round-robin from ptr
//           req_valid, req    request vector handshake (input side)
//           req_ready         block can accept req this cycle
//           out_valid         registered result valid
//           out_ready         consumer accepts the result
//           out_index         winning bit index
//           out_none          accepted vector was all-zero
//           out_multi         accepted vector had two or more bits set
// -----------------------------------------------------------------------------
module prio_enc_rr
  import prio_enc_rr_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             rr_en,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req,
  output logic             req_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_none,
  output logic             out_multi
);

  prio_mode_e       mode;
  logic             accept;
  logic [IDX_W-1:0] search_ptr;
  logic [IDX_W-1:0] srch_index;
  logic             srch_none;
  logic             srch_multi;

  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_index_q, out_index_d;
  logic             out_none_q,  out_none_d;
  logic             out_multi_q, out_multi_d;
  logic [IDX_W-1:0] ptr_q,       ptr_d;

  assign mode = prio_mode_e'(rr_en);

  // The output register frees up in the same cycle it is drained, so a new
  // request can be taken while the consumer is reading the old result.
  assign req_ready = enable & (~out_valid_q | out_ready);
  assign accept    = req_valid & req_ready;

  // Fixed mode is a round-robin search that always starts at bit 0; ptr_q is
  // left untouched so the round-robin history survives mode switches.
  assign search_ptr = (mode == MODE_RR) ? ptr_q : '0;

  prio_search #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_search (
    .req   (req),
    .ptr   (search_ptr),
    .index (srch_index),
    .none  (srch_none),
    .multi (srch_multi)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    out_none_d  = out_none_q;
    out_multi_d = out_multi_q;
    ptr_d       = ptr_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_index_d = srch_index;
      out_none_d  = srch_none;
      out_multi_d = srch_multi;
      // Advance past the winner; explicit wrap keeps ptr below WIDTH even
      // when WIDTH is not a power of two.
      if ((mode == MODE_RR) && !srch_none) begin
        if (srch_index == IDX_W'(WIDTH - 1)) ptr_d = '0;
        else                                 ptr_d = srch_index + IDX_W'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // ---- output / pointer register stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_none_q  <= 1'b0;
      out_multi_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      out_none_q  <= out_none_d;
      out_multi_q <= out_multi_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign out_none  = out_none_q;
  assign out_multi = out_multi_q;

endmodule

// File: tb/tb_prio_enc_rr.sv
module tb_prio_enc_rr;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        rr_en;
  logic        req_valid;
  logic [15:0] req;
  logic        req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_index;
  logic        out_none;
  logic        out_multi;

  logic        enable5;
  logic        rr_en5;
  logic        req_valid5;
  logic [4:0]  req5;
  logic        req_ready5;
  logic        out_valid5;
  logic        out_ready5;
  logic [2:0]  out_index5;
  logic        out_none5;
  logic        out_multi5;

  int total;
  int bad;

  prio_enc_rr #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .rr_en     (rr_en),
    .req_valid (req_valid),
    .req       (req),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_none  (out_none),
    .out_multi (out_multi)
  );

  prio_enc_rr #(.WIDTH(5)) dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable5),
    .rr_en     (rr_en5),
    .req_valid (req_valid5),
    .req       (req5),
    .req_ready (req_ready5),
    .out_valid (out_valid5),
    .out_ready (out_ready5),
    .out_index (out_index5),
    .out_none  (out_none5),
    .out_multi (out_multi5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; enable = 1'b1; rr_en = 1'b0; req_valid = 1'b0; req = '0; out_ready = 1'b1;
    enable5 = 1'b0; rr_en5 = 1'b0; req_valid5 = 1'b0; req5 = '0; out_ready5 = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    total++; if (out_index !== 4'd0) begin bad++; $display("FAIL reset_index got=%0d exp=0", out_index); end
    total++; if (out_none !== 1'b0 || out_multi !== 1'b0) begin bad++; $display("FAIL reset_flags got=%0b%0b exp=00", out_none, out_multi); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_held_valid got=%0b exp=0", out_valid); end
    rst_n = 1'b1;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", req_ready); end
  endtask

  task automatic test_fixed_onehot();
    rr_en = 1'b0; req_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req = 16'(1 << i);
      step();
      total++;
      if (out_valid !== 1'b1 || out_index !== 4'(i) || out_multi !== 1'b0 || out_none !== 1'b0) begin
        bad++;
        $display("FAIL onehot_%0d got v=%0b idx=%0d m=%0b n=%0b exp v=1 idx=%0d m=0 n=0",
                 i, out_valid, out_index, out_multi, out_none, i);
      end
    end
  endtask

  task automatic test_fixed_multi();
    req = 16'h8421;
    step();
    total++; if (out_index !== 4'd0 || out_multi !== 1'b1 || out_none !== 1'b0) begin bad++;
      $display("FAIL fixed_8421 got idx=%0d m=%0b n=%0b exp idx=0 m=1 n=0", out_index, out_multi, out_none); end
    req = 16'h0000;
    step();
    total++; if (out_valid !== 1'b1 || out_index !== 4'd0 || out_none !== 1'b1 || out_multi !== 1'b0) begin bad++;
      $display("FAIL fixed_zero got v=%0b idx=%0d n=%0b m=%0b exp v=1 idx=0 n=1 m=0", out_valid, out_index, out_none, out_multi); end
    req = 16'h0c00;
    step();
    total++; if (out_index !== 4'd10 || out_multi !== 1'b1) begin bad++;
      $display("FAIL fixed_0c00 got idx=%0d m=%0b exp idx=10 m=1", out_index, out_multi); end
  endtask

  task automatic test_rr_wrap();
    rr_en = 1'b1; req = 16'hFFFF; req_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      step();
      total++;
      if (out_valid !== 1'b1 || out_index !== 4'(k % 16) || out_multi !== 1'b1) begin
        bad++;
        $display("FAIL rr_wrap_%0d got v=%0b idx=%0d m=%0b exp v=1 idx=%0d m=1",
                 k, out_valid, out_index, out_multi, k % 16);
      end
    end
  endtask

  task automatic test_back_to_back();
    rr_en = 1'b0; req = 16'h0010; req_valid = 1'b1; out_ready = 1'b1;
    step();
    total++; if (out_index !== 4'd4) begin bad++; $display("FAIL bp_first got=%0d exp=4", out_index); end
    out_ready = 1'b0; req = 16'h0002;
    #1;
    for (int c = 0; c < 5; c++) begin
      total++;
      if (req_ready !== 1'b0 || out_valid !== 1'b1 || out_index !== 4'd4 || out_none !== 1'b0 || out_multi !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold_%0d got rdy=%0b v=%0b idx=%0d exp rdy=0 v=1 idx=4", c, req_ready, out_valid, out_index);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%0b exp=1", req_ready); end
    step();
    total++; if (out_valid !== 1'b1 || out_index !== 4'd1) begin bad++;
      $display("FAIL bp_no_bubble got v=%0b idx=%0d exp v=1 idx=1", out_valid, out_index); end
    req_valid = 1'b0;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_enable();
    // ptr is 1 after the round-robin wrap; winner 3 moves it to 4.
    rr_en = 1'b1; req = 16'h0008; req_valid = 1'b1; out_ready = 1'b1; enable = 1'b1;
    step();
    total++; if (out_index !== 4'd3) begin bad++; $display("FAIL en_first got=%0d exp=3", out_index); end
    out_ready = 1'b0; enable = 1'b0; req = 16'hFFFF;
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL en_ready got=%0b exp=0", req_ready); end
    for (int c = 0; c < 2; c++) begin
      step();
      total++; if (out_valid !== 1'b1 || out_index !== 4'd3) begin bad++;
        $display("FAIL en_hold_%0d got v=%0b idx=%0d exp v=1 idx=3", c, out_valid, out_index); end
    end
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL en_drain got=%0b exp=0", out_valid); end
    enable = 1'b1;
    step();
    total++; if (out_valid !== 1'b1 || out_index !== 4'd4) begin bad++;
      $display("FAIL en_ptr_kept got v=%0b idx=%0d exp v=1 idx=4", out_valid, out_index); end
  endtask

  task automatic test_reset_mid();
    // ptr is now 5 with a result held on the output.
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_index !== 4'd0 || out_none !== 1'b0 || out_multi !== 1'b0) begin bad++;
      $display("FAIL mid_reset got v=%0b idx=%0d n=%0b m=%0b exp all 0", out_valid, out_index, out_none, out_multi); end
    step();
    req_valid = 1'b0;
    rst_n = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_no_ghost got=%0b exp=0", out_valid); end
    rr_en = 1'b1; req = 16'h0021; req_valid = 1'b1; out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b1 || out_index !== 4'd0) begin bad++;
      $display("FAIL mid_ptr_zero got v=%0b idx=%0d exp v=1 idx=0", out_valid, out_index); end
    step();
    total++; if (out_index !== 4'd5) begin bad++; $display("FAIL mid_ptr_next got=%0d exp=5", out_index); end
    req_valid = 1'b0;
    step();
  endtask

  task automatic test_odd_width();
    enable5 = 1'b1; rr_en5 = 1'b1; req5 = 5'b11111; req_valid5 = 1'b1; out_ready5 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      total++;
      if (out_valid5 !== 1'b1 || out_index5 !== 3'(k % 5)) begin
        bad++;
        $display("FAIL odd_rr_%0d got v=%0b idx=%0d exp v=1 idx=%0d", k, out_valid5, out_index5, k % 5);
      end
    end
    req5 = 5'b00001;
    step();
    total++; if (out_index5 !== 3'd0 || out_multi5 !== 1'b0 || out_none5 !== 1'b0) begin bad++;
      $display("FAIL odd_single got idx=%0d m=%0b n=%0b exp idx=0 m=0 n=0", out_index5, out_multi5, out_none5); end
    req_valid5 = 1'b0;
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_fixed_onehot();
    test_fixed_multi();
    test_rr_wrap();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    test_odd_width();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
